send_cmd_scheduler: RTL and testbench

Queues packet-send commands from the two MAC send channels and arbitrates them onto one shared DDR-read/packet-fetch engine. Each channel supplies a 25-bit DDR start address and a cmd_send pulse. The block issues one command at a time using round-robin arbitration, waits for completion, and applies a timeout. It sits between the channel command sources and the DDR Avalon-side fetch engine, in the ddr_avalon clock domain.

---
 rtl/send_cmd_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_send_cmd_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/send_cmd_scheduler.sv
// send_cmd_scheduler: per-channel command FIFOs feeding a round-robin arbiter
// that issues one DDR fetch command at a time, waits for completion with a
// timeout, and keeps sticky error and drop accounting.
//
// state       | meaning
// S_IDLE      | no command outstanding; grant when DDR ready and a FIFO has data
// S_ISSUE     | fetch_cmd_valid high, address/port held until the engine accepts
// S_WAIT_DONE | command accepted, counting cycles until fetch_done or timeout
module send_cmd_scheduler #(
    parameter int ADDR_W      = 25,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clock_clk,
    input  logic              reset_reset_n,
    input  logic              ddr_ready_ram_ready,
    input  logic [ADDR_W-1:0] send_packet_1_control_start_ram_addr,
    input  logic              send_packet_1_control_cmd_send,
    input  logic [ADDR_W-1:0] send_packet_2_control_start_ram_addr,
    input  logic              send_packet_2_control_cmd_send,
    output logic [ADDR_W-1:0] fetch_cmd_start_ram_addr,
    output logic              fetch_cmd_port_sel,
    output logic              fetch_cmd_valid,
    input  logic              fetch_cmd_ready,
    input  logic              fetch_done,
    input  logic              err_clear,
    output logic              busy,
    output logic              timeout_err,
    output logic              drop_1,
    output logic              drop_2,
    output logic [7:0]        drop_cnt_1,
    output logic [7:0]        drop_cnt_2
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_mem   [2][FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr  [2];
    logic [PTR_W-1:0]  r_rptr  [2];
    logic [CNT_W-1:0]  r_count [2];
    logic [ADDR_W-1:0] w_addr_in [2];
    logic [ADDR_W-1:0] w_pop_addr;
    logic [1:0]        w_req;
    logic [1:0]        w_full;
    logic [1:0]        w_nonempty;
    logic [1:0]        w_pop;
    logic [1:0]        w_push;
    logic [1:0]        w_drop;
    logic              w_grant;
    logic              w_grant_sel;
    logic              w_timeout;
    logic              r_busy;
    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic              r_sel;
    logic              r_last_sel;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic              r_timeout_err;
    logic [1:0]        r_drop;
    logic [7:0]        r_drop_cnt [2];

    // FIFO occupancy status, kept apart from push/pop so the arbiter reads it loop-free
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            w_full[ch]     = (r_count[ch] == FULL_CNT);
            w_nonempty[ch] = (r_count[ch] != '0);
        end
    end

    // Push/pop/drop decisions; a full FIFO still accepts when it is popped this cycle
    always_comb begin
        w_req        = {send_packet_2_control_cmd_send, send_packet_1_control_cmd_send};
        w_addr_in[0] = send_packet_1_control_start_ram_addr;
        w_addr_in[1] = send_packet_2_control_start_ram_addr;
        for (int ch = 0; ch < 2; ch++) begin
            w_pop[ch]  = w_grant && (w_grant_sel == 1'(ch));
            w_push[ch] = w_req[ch] && (!w_full[ch] || w_pop[ch]);
            w_drop[ch] = w_req[ch] && w_full[ch] && !w_pop[ch];
        end
        w_pop_addr = r_mem[w_grant_sel][r_rptr[w_grant_sel]];
    end

    // Next-state and grant selection; the channel that did not win last time has priority
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_grant_sel = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ddr_ready_ram_ready && (|w_nonempty)) begin
                    w_grant     = 1'b1;
                    w_grant_sel = (&w_nonempty) ? ~r_last_sel : w_nonempty[1];
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (fetch_cmd_ready) w_state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (fetch_done) begin
                    w_state_nxt = S_IDLE;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FIFO storage; contents need no reset since occupancy is tracked separately
    always_ff @(posedge clock_clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            if (w_push[ch]) r_mem[ch][r_wptr[ch]] <= w_addr_in[ch];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int ch = 0; ch < 2; ch++) begin
                r_wptr[ch]  <= '0;
                r_rptr[ch]  <= '0;
                r_count[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (w_push[ch]) r_wptr[ch] <= r_wptr[ch] + PTR_W'(1);
                if (w_pop[ch])  r_rptr[ch] <= r_rptr[ch] + PTR_W'(1);
                if (w_push[ch] && !w_pop[ch])      r_count[ch] <= r_count[ch] + CNT_W'(1);
                else if (!w_push[ch] && w_pop[ch]) r_count[ch] <= r_count[ch] - CNT_W'(1);
            end
        end
    end

    // State register plus registered command outputs, timeout counter and sticky error
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_valid       <= 1'b0;
            r_addr        <= '0;
            r_sel         <= 1'b0;
            r_last_sel    <= 1'b1;
            r_tmo_cnt     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_valid <= (w_state_nxt == S_ISSUE);
            if (w_grant) begin
                r_addr     <= w_pop_addr;
                r_sel      <= w_grant_sel;
                r_last_sel <= w_grant_sel;
            end
            if (r_state == S_ISSUE)          r_tmo_cnt <= '0;
            else if (r_state == S_WAIT_DONE) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            if (w_timeout)      r_timeout_err <= 1'b1;
            else if (err_clear) r_timeout_err <= 1'b0;
        end
    end

    // Drop pulses and saturating drop counters; a drop coinciding with err_clear counts as 1
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_drop <= '0;
            for (int ch = 0; ch < 2; ch++) r_drop_cnt[ch] <= '0;
        end else begin
            r_drop <= w_drop;
            for (int ch = 0; ch < 2; ch++) begin
                if (err_clear)
                    r_drop_cnt[ch] <= {7'd0, w_drop[ch]};
                else if (w_drop[ch] && (r_drop_cnt[ch] != 8'hFF))
                    r_drop_cnt[ch] <= r_drop_cnt[ch] + 8'd1;
            end
        end
    end

    assign fetch_cmd_start_ram_addr = r_addr;
    assign fetch_cmd_port_sel       = r_sel;
    assign fetch_cmd_valid          = r_valid;
    assign busy                     = r_busy;
    assign timeout_err              = r_timeout_err;
    assign drop_1                   = r_drop[0];
    assign drop_2                   = r_drop[1];
    assign drop_cnt_1               = r_drop_cnt[0];
    assign drop_cnt_2               = r_drop_cnt[1];

endmodule

// File: tb/tb_send_cmd_scheduler.sv
// Testbench for send_cmd_scheduler: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_send_cmd_scheduler;

    localparam int AW    = 25;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          ddr_rdy = 1'b0;
    logic [AW-1:0] a1 = '0;
    logic [AW-1:0] a2 = '0;
    logic          c1 = 1'b0;
    logic          c2 = 1'b0;
    logic          fetch_ready = 1'b0;
    logic          fetch_done_i = 1'b0;
    logic          eclr = 1'b0;

    logic [AW-1:0] o_addr;
    logic          o_sel, o_valid, o_busy, o_err, o_drop1, o_drop2;
    logic [7:0]    o_cnt1, o_cnt2;

    int n_pass = 0;
    int n_total = 0;

    send_cmd_scheduler #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clock_clk                            (clk),
        .reset_reset_n                        (rst_n),
        .ddr_ready_ram_ready                  (ddr_rdy),
        .send_packet_1_control_start_ram_addr (a1),
        .send_packet_1_control_cmd_send       (c1),
        .send_packet_2_control_start_ram_addr (a2),
        .send_packet_2_control_cmd_send       (c2),
        .fetch_cmd_start_ram_addr             (o_addr),
        .fetch_cmd_port_sel                   (o_sel),
        .fetch_cmd_valid                      (o_valid),
        .fetch_cmd_ready                      (fetch_ready),
        .fetch_done                           (fetch_done_i),
        .err_clear                            (eclr),
        .busy                                 (o_busy),
        .timeout_err                          (o_err),
        .drop_1                               (o_drop1),
        .drop_2                               (o_drop2),
        .drop_cnt_1                           (o_cnt1),
        .drop_cnt_2                           (o_cnt2)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // phase: 0 = no command held, 1 = command offered, 2 = command accepted
    logic [AW-1:0] mq1 [$];
    logic [AW-1:0] mq2 [$];
    int            m_phase = 0;
    int            m_last = 1;
    int            m_waited = 0;
    logic [AW-1:0] e_addr = '0;
    logic          e_sel = 1'b0;
    logic          e_err = 1'b0;
    logic [1:0]    e_drop = '0;
    int            e_cnt [2] = '{0, 0};
    int            gch;
    bit            tmo;
    bit [1:0]      mdrop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq1.delete();
            mq2.delete();
            m_phase = 0; m_last = 1; m_waited = 0;
            e_addr = '0; e_sel = 1'b0; e_err = 1'b0; e_drop = '0;
            e_cnt[0] = 0; e_cnt[1] = 0;
        end else begin
            tmo = 1'b0;
            if (m_phase == 0) begin
                if (ddr_rdy && (mq1.size() > 0 || mq2.size() > 0)) begin
                    if (mq1.size() > 0 && mq2.size() > 0) gch = 1 - m_last;
                    else gch = (mq1.size() > 0) ? 0 : 1;
                    e_addr  = (gch == 0) ? mq1.pop_front() : mq2.pop_front();
                    e_sel   = (gch == 1);
                    m_last  = gch;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (fetch_ready) begin m_phase = 2; m_waited = 0; end
            end else begin
                m_waited++;
                if (fetch_done_i) m_phase = 0;
                else if (m_waited == TMO) begin tmo = 1'b1; m_phase = 0; end
            end
            mdrop = '0;
            if (c1) begin
                if (mq1.size() < DEPTH) mq1.push_back(a1); else mdrop[0] = 1'b1;
            end
            if (c2) begin
                if (mq2.size() < DEPTH) mq2.push_back(a2); else mdrop[1] = 1'b1;
            end
            e_drop = mdrop;
            for (int ch = 0; ch < 2; ch++) begin
                if (eclr) e_cnt[ch] = mdrop[ch] ? 1 : 0;
                else if (mdrop[ch] && e_cnt[ch] < 255) e_cnt[ch]++;
            end
            if (tmo) e_err = 1'b1;
            else if (eclr) e_err = 1'b0;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic compare_all();
        if (rst_n) begin
            chk("valid", 32'(o_valid), 32'(m_phase == 1));
            chk("busy", 32'(o_busy), 32'(m_phase != 0));
            chk("timeout_err", 32'(o_err), 32'(e_err));
            chk("drop_1", 32'(o_drop1), 32'(e_drop[0]));
            chk("drop_2", 32'(o_drop2), 32'(e_drop[1]));
            chk("drop_cnt_1", 32'(o_cnt1), 32'(e_cnt[0]));
            chk("drop_cnt_2", 32'(o_cnt2), 32'(e_cnt[1]));
            if (m_phase == 1) begin
                chk("addr", 32'(o_addr), 32'(e_addr));
                chk("port_sel", 32'(o_sel), 32'(e_sel));
            end
        end
    endtask

    // ---------------- fetch engine stand-in ----------------
    logic [AW:0] issued [$];
    bit eng_on = 1'b0, eng_fast = 1'b0, eng_spur = 1'b0, eng_wait = 1'b0;
    int eng_delay = 0;

    task automatic engine_step();
        fetch_done_i = 1'b0;
        if (eng_wait) begin
            if (eng_delay == 0) begin fetch_done_i = 1'b1; eng_wait = 1'b0; end
            else eng_delay--;
        end else if (eng_spur && $urandom_range(0, 15) == 0) begin
            fetch_done_i = 1'b1;
        end
        fetch_ready = eng_fast ? 1'b1 : ($urandom_range(0, 3) != 0);
        if (o_valid && fetch_ready) begin
            issued.push_back({o_sel, o_addr});
            eng_wait  = 1'b1;
            eng_delay = eng_fast ? 0 : int'($urandom_range(0, 18));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        if (eng_on) engine_step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        c1 = 1'b0; c2 = 1'b0; ddr_rdy = 1'b0; eclr = 1'b0;
        fetch_ready = 1'b0; fetch_done_i = 1'b0;
        eng_on = 1'b0; eng_fast = 1'b0; eng_spur = 1'b0; eng_wait = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] iss(input int i);
        return (i < issued.size()) ? 32'(issued[i]) : 32'hFFFF_FFFF;
    endfunction

    task automatic wait_issued(input int n, input int budget, input string nm);
        int k = 0;
        while (issued.size() < n && k < budget) begin tick(); k++; end
        chk(nm, 32'(issued.size() >= n), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        #2;
        do_reset();
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_addr", 32'(o_addr), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_cnt2", 32'(o_cnt2), 32'd0);

        // single command latency and completion
        ddr_rdy = 1'b1;
        tick();
        c1 = 1'b1; a1 = 25'h0001234;
        tick();
        c1 = 1'b0;
        chk("lat_n1_valid", 32'(o_valid), 32'd0);
        tick();
        chk("lat_n2_valid", 32'(o_valid), 32'd1);
        chk("lat_n2_addr", 32'(o_addr), 32'h0001234);
        chk("lat_n2_sel", 32'(o_sel), 32'd0);
        fetch_ready = 1'b1;
        tick();
        fetch_ready = 1'b0;
        chk("hs_valid_low", 32'(o_valid), 32'd0);
        chk("hs_busy", 32'(o_busy), 32'd1);
        fetch_done_i = 1'b1;
        tick();
        fetch_done_i = 1'b0;
        chk("done_busy_low", 32'(o_busy), 32'd0);

        // round-robin order
        do_reset();
        c1 = 1'b1; a1 = 25'h0000A01; c2 = 1'b1; a2 = 25'h0000B01;
        tick();
        a1 = 25'h0000A02; a2 = 25'h0000B02;
        tick();
        c1 = 1'b0; c2 = 1'b0;
        base = issued.size();
        eng_on = 1'b1; eng_fast = 1'b1; ddr_rdy = 1'b1;
        wait_issued(base + 4, 100, "rr_progress");
        chk("rr_0", iss(base),     {6'd0, 1'b0, 25'h0000A01});
        chk("rr_1", iss(base + 1), {6'd0, 1'b1, 25'h0000B01});
        chk("rr_2", iss(base + 2), {6'd0, 1'b0, 25'h0000A02});
        chk("rr_3", iss(base + 3), {6'd0, 1'b1, 25'h0000B02});

        // overflow and saturation on channel 2
        do_reset();
        for (int i = 0; i < 5; i++) begin
            c2 = 1'b1; a2 = AW'(100 + i);
            tick();
            if (i == 3) chk("ovf_no_drop_at_4", 32'(o_drop2), 32'd0);
        end
        c2 = 1'b0;
        chk("ovf_drop_2", 32'(o_drop2), 32'd1);
        chk("ovf_cnt_2", 32'(o_cnt2), 32'd1);
        tick();
        chk("ovf_drop_once", 32'(o_drop2), 32'd0);
        c2 = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        c2 = 1'b0;
        chk("ovf_sat", 32'(o_cnt2), 32'd255);
        chk("ovf_cnt_1", 32'(o_cnt1), 32'd0);
        eclr = 1'b1;
        tick();
        eclr = 1'b0;
        chk("ovf_cleared", 32'(o_cnt2), 32'd0);
        base = issued.size();
        eng_on = 1'b1; eng_fast = 1'b1; ddr_rdy = 1'b1;
        wait_issued(base + 4, 100, "ovf_drain");
        for (int i = 0; i < 4; i++) chk("ovf_order", iss(base + i), {6'd0, 1'b1, AW'(100 + i)});

        // full FIFO with a pop in the same cycle
        do_reset();
        for (int i = 0; i < 4; i++) begin c1 = 1'b1; a1 = AW'(200 + i); tick(); end
        ddr_rdy = 1'b1; a1 = AW'(204);
        tick();
        c1 = 1'b0;
        chk("fp_no_drop", 32'(o_drop1), 32'd0);
        chk("fp_cnt", 32'(o_cnt1), 32'd0);
        base = issued.size();
        eng_on = 1'b1; eng_fast = 1'b1;
        wait_issued(base + 5, 100, "fp_drain");
        for (int i = 0; i < 5; i++) chk("fp_order", iss(base + i), {6'd0, 1'b0, AW'(200 + i)});

        // timeout, clear, done-wins, set-wins
        do_reset();
        ddr_rdy = 1'b1;
        for (int t = 0; t < 3; t++) begin
            c1 = 1'b1; a1 = AW'(300 + t);
            tick();
            c1 = 1'b0;
            tick();
            fetch_ready = 1'b1;
            tick();
            fetch_ready = 1'b0;
            for (int k = 0; k < 15; k++) tick();
            chk("tmo_not_yet", 32'(o_busy), 32'd1);
            if (t == 1) fetch_done_i = 1'b1;
            if (t == 2) eclr = 1'b1;
            tick();
            fetch_done_i = 1'b0; eclr = 1'b0;
            chk("tmo_idle", 32'(o_busy), 32'd0);
            chk("tmo_err", 32'(o_err), (t == 1) ? 32'd0 : 32'd1);
            if (t != 1) begin
                eclr = 1'b1;
                tick();
                eclr = 1'b0;
                chk("tmo_clear", 32'(o_err), 32'd0);
            end
        end

        // ready stall, then reset in the middle of WAIT_DONE
        do_reset();
        ddr_rdy = 1'b1;
        c1 = 1'b1; a1 = 25'h1ABCDEF;
        tick();
        c1 = 1'b0;
        tick();
        ddr_rdy = 1'b0;
        for (int k = 0; k < 20; k++) begin
            chk("stall_valid", 32'(o_valid), 32'd1);
            chk("stall_addr", 32'(o_addr), 32'h1ABCDEF);
            chk("stall_sel", 32'(o_sel), 32'd0);
            tick();
        end
        fetch_ready = 1'b1; c2 = 1'b1; a2 = 25'h0000C0C;
        tick();
        fetch_ready = 1'b0; c2 = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(o_valid), 32'd0);
        chk("arst_busy", 32'(o_busy), 32'd0);
        chk("arst_addr", 32'(o_addr), 32'd0);
        chk("arst_err", 32'(o_err), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; ddr_rdy = 1'b1;
        tick(); tick(); tick();
        chk("arst_fifo_empty", 32'(o_busy), 32'd0);
        c1 = 1'b1; a1 = 25'h0000D01; c2 = 1'b1; a2 = 25'h0000D02;
        tick();
        c1 = 1'b0; c2 = 1'b0;
        base = issued.size();
        eng_on = 1'b1; eng_fast = 1'b1;
        wait_issued(base + 2, 100, "arst_drain");
        chk("arst_first_ch1", iss(base), {6'd0, 1'b0, 25'h0000D01});

        // random traffic against the model
        do_reset();
        ddr_rdy = 1'b1;
        eng_on = 1'b1; eng_fast = 1'b0; eng_spur = 1'b1;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            c1 = ($urandom_range(0, 5) == 0);
            a1 = AW'($urandom);
            c2 = ($urandom_range(0, 5) == 0);
            a2 = AW'($urandom);
            if ($urandom_range(0, 49) == 0) ddr_rdy = ~ddr_rdy;
            eclr = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
